// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing helpers for the sequential divider
package div_pkg;

  localparam int DIV_STATE_W = 2;

  typedef enum logic [DIV_STATE_W-1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  // Bits needed to count 0..width restoring steps
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift the next dividend bit in, trial-subtract, keep or restore.
  // The extra top bit of trial acts as the borrow/sign of the subtraction.
  always_comb begin
    shifted = {rem_in, dvd_msb};
    trial   = shifted - {1'b0, dvs};
    q_bit   = ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle signed/unsigned restoring divider, remainder on high, quotient on low
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low,
  output logic             busy,
  output logic             div_end,
  output logic             div_zero
);

  localparam int                CNT_W     = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state;
  div_state_e       state_d;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;   // dividend shifts out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvs_q;
  logic             q_neg;
  logic             r_neg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic             b_zero;
  logic             start;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Operand magnitudes and start qualification; MIN negates to itself, which is its correct unsigned magnitude
  always_comb begin
    b_zero = (b == '0);
    start  = (state == DIV_IDLE) && div && !b_zero;
    a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_msb (dvd_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // Next-state selection: IDLE -> CALC for WIDTH steps -> FIX -> IDLE
  always_comb begin
    state_d = state;
    case (state)
      DIV_IDLE: if (start) state_d = DIV_CALC;
      DIV_CALC: if (cnt == LAST_STEP) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_d;
  end

  // Datapath and registered outputs: capture, iterate, sign-fix and publish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      cnt      <= '0;
      high     <= '0;
      low      <= '0;
      busy     <= 1'b0;
      div_end  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      div_end <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (div) begin
            if (b_zero) begin
              div_zero <= 1'b1;
              div_end  <= 1'b1;
            end else begin
              rem_q    <= '0;
              dvd_q    <= a_mag;
              dvs_q    <= b_mag;
              q_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg    <= is_signed & a[WIDTH-1];
              cnt      <= '0;
              div_zero <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        DIV_CALC: begin
          rem_q <= rem_nxt;
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
          cnt   <= cnt + CNT_W'(1);
        end
        DIV_FIX: begin
          low     <= q_neg ? -dvd_q : dvd_q;
          high    <= r_neg ? -rem_q : rem_q;
          div_end <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - randomized self-checking bench for div_seq at WIDTH 32 and 8
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        div32, s32, busy32, end32, zero32;
  logic [31:0] a32, b32, high32, low32;
  logic        div8, s8, busy8, end8, zero8;
  logic [7:0]  a8, b8, high8, low8;

  int          n_checks = 0;
  int          n_err    = 0;
  bit          cur8     = 1'b0;
  logic [63:0] last_q[2];
  logic [63:0] last_r[2];

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .div(div32), .is_signed(s32), .a(a32), .b(b32),
    .high(high32), .low(low32), .busy(busy32), .div_end(end32), .div_zero(zero32)
  );

  div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .div(div8), .is_signed(s8), .a(a8), .b(b8),
    .high(high8), .low(low8), .busy(busy8), .div_end(end8), .div_zero(zero8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] o_high();  return cur8 ? {56'd0, high8} : {32'd0, high32}; endfunction
  function automatic logic [63:0] o_low();   return cur8 ? {56'd0, low8}  : {32'd0, low32};  endfunction
  function automatic logic        o_end();   return cur8 ? end8  : end32;  endfunction
  function automatic logic        o_busy();  return cur8 ? busy8 : busy32; endfunction
  function automatic logic        o_zero();  return cur8 ? zero8 : zero32; endfunction

  // Reference: plain integer division; SV '/' and '%' truncate toward zero with remainder sign of dividend
  function automatic void ref_div(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input bit s, output logic [63:0] q, output logic [63:0] r);
    logic [63:0] m;
    longint      sa, sb;
    m = (64'd1 << w) - 64'd1;
    if (!s) begin
      q = (a & m) / (b & m);
      r = (a & m) % (b & m);
    end else begin
      sa = longint'((a & m) << (64 - w)) >>> (64 - w);
      sb = longint'((b & m) << (64 - w)) >>> (64 - w);
      q  = 64'(sa / sb) & m;
      r  = 64'(sa % sb) & m;
    end
  endfunction

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input bit s, input logic d);
    if (cur8) begin
      a8 = a[7:0];  b8 = b[7:0];  s8 = s;  div8 = d;
    end else begin
      a32 = a[31:0]; b32 = b[31:0]; s32 = s; div32 = d;
    end
  endtask

  // Called #1 after an edge; the following edge is the accepting edge
  task automatic launch(input logic [63:0] a, input logic [63:0] b, input bit s);
    drive(a, b, s, 1'b1);
    @(posedge clk); #1;
    drive(a, b, s, 1'b0);
  endtask

  // k = edges after the accepting edge when div_end is seen; bc = sampled busy cycles
  task automatic wait_end(output int k, output int bc);
    k = 0; bc = 0;
    while (!o_end() && k < 200) begin
      if (o_busy()) bc++;
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit s, input string tag);
    int          w, k, bc, idx;
    logic [63:0] m, q, r;
    w   = cur8 ? 8 : 32;
    idx = cur8 ? 1 : 0;
    m   = (64'd1 << w) - 64'd1;
    launch(a, b, s);
    wait_end(k, bc);
    check({tag, "_end"}, 64'(o_end()), 64'd1);
    if ((b & m) == 64'd0) begin
      check({tag, "_lat"},  64'(k), 64'd0);
      check({tag, "_busy"}, 64'(o_busy()), 64'd0);
      check({tag, "_zero"}, 64'(o_zero()), 64'd1);
    end else begin
      ref_div(w, a, b, s, q, r);
      last_q[idx] = q;
      last_r[idx] = r;
      check({tag, "_lat"},   64'(k),  64'(w + 1));
      check({tag, "_bcyc"},  64'(bc), 64'(w + 1));
      check({tag, "_zero"},  64'(o_zero()), 64'd0);
    end
    check({tag, "_high"}, o_high(), last_r[idx]);
    check({tag, "_low"},  o_low(),  last_q[idx]);
  endtask

  initial begin
    int          k, bc, ends;
    logic [63:0] ra, rb;
    bit          rs;

    reset = 1'b1;
    {div32, s32, a32, b32} = '0;
    {div8, s8, a8, b8}     = '0;
    last_q = '{64'd0, 64'd0};
    last_r = '{64'd0, 64'd0};
    @(posedge clk); #1;
    check("rst_high32", 64'(high32), 64'd0);
    check("rst_low32",  64'(low32),  64'd0);
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_end32",  64'(end32),  64'd0);
    check("rst_zero32", 64'(zero32), 64'd0);
    check("rst_low8",   64'(low8),   64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed WIDTH=32 cases
    cur8 = 1'b0;
    run_op(64'd100, 64'd7, 1'b0, "u100_7");
    check("u100_7_low_c",  o_low(),  64'd14);
    check("u100_7_high_c", o_high(), 64'd2);
    run_op(64'hFFFF_FFF9, 64'd2, 1'b1, "s_m7_2");
    check("s_m7_2_low_c",  o_low(),  64'hFFFF_FFFD);
    check("s_m7_2_high_c", o_high(), 64'hFFFF_FFFF);
    run_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, "s_ovf");
    check("s_ovf_low_c",  o_low(),  64'h8000_0000);
    check("s_ovf_high_c", o_high(), 64'd0);
    run_op(64'd100, 64'd7, 1'b0, "pre_dz");
    run_op(64'd5, 64'd0, 1'b0, "dz");
    check("dz_high_c", o_high(), 64'd2);
    check("dz_low_c",  o_low(),  64'd14);
    @(posedge clk); #1;
    check("dz_end_once", 64'(end32), 64'd0);
    run_op(64'd20, 64'd6, 1'b0, "after_dz");

    // Start requested while busy must be ignored
    @(posedge clk); #1;
    launch(64'd1000, 64'd3, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    drive(64'd50, 64'd5, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(64'd50, 64'd5, 1'b0, 1'b0);
    wait_end(k, bc);
    check("ign_lat",  64'(k + 5), 64'd33);
    check("ign_low",  o_low(),  64'd333);
    check("ign_high", o_high(), 64'd1);
    last_q[0] = 64'd333;
    last_r[0] = 64'd1;
    @(posedge clk); #1;
    check("ign_no_2nd", 64'(end32) | 64'(busy32), 64'd0);

    // Reset mid-operation aborts without a completion pulse
    launch(64'd1000, 64'd3, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("abort_high", 64'(high32), 64'd0);
    check("abort_low",  64'(low32),  64'd0);
    check("abort_busy", 64'(busy32), 64'd0);
    check("abort_end",  64'(end32),  64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_q = '{64'd0, 64'd0};
    last_r = '{64'd0, 64'd0};
    ends = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (end32 || busy32) ends++;
    end
    check("abort_quiet", 64'(ends), 64'd0);
    run_op(64'd9, 64'd3, 1'b0, "post_rst");
    check("post_rst_low_c",  o_low(),  64'd3);
    check("post_rst_high_c", o_high(), 64'd0);

    // WIDTH=8 with a back-to-back start in the div_end cycle
    cur8 = 1'b1;
    @(posedge clk); #1;
    run_op(64'hFF, 64'h10, 1'b0, "w8_ff_10");
    check("w8_low_c",  o_low(),  64'h0F);
    check("w8_high_c", o_high(), 64'h0F);
    run_op(64'hC8, 64'h07, 1'b1, "w8_b2b");

    // Random mix across both widths, signedness, zero divisors and overflow
    for (int i = 0; i < 40; i++) begin
      cur8 = bit'($urandom_range(0, 1));
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rs   = bit'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: rb = 64'd0;
        1: rb = rb & 64'hF;
        2: begin
          ra = cur8 ? 64'h80 : 64'h8000_0000;
          rb = 64'hFFFF_FFFF_FFFF_FFFF;
          rs = 1'b1;
        end
        default: ;
      endcase
      run_op(ra, rb, rs, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Parametrised multi-cycle restoring integer divider for the datapath's HI/LO unit. It supports signed and unsigned division of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock. It uses a start/busy/done handshake with early divide-by-zero termination. Results go to `high` (remainder) and `low` (quotient), matching the multiplier's HI/LO convention.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width; legal values are 4 to 64.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `div` input, 1 bit: start request. Sampled only in IDLE.
- `is_signed` input, 1 bit: 1 selects two's-complement division, 0 selects unsigned. Captured together with `div`.
- `a` input, WIDTH bits: dividend. Captured when `div` is accepted.
- `b` input, WIDTH bits: divisor. Captured when `div` is accepted.
- `high` output, WIDTH bits: remainder of the last completed division.
- `low` output, WIDTH bits: quotient of the last completed division.
- `busy` output, 1 bit: high from the accepted start until the result is written.
- `div_end` output, 1 bit: one-cycle completion pulse.
- `div_zero` output, 1 bit: level flag. Set when the last accepted operation had `b == 0`.

## Operation
- **Reset values:** `high`, `low`, `busy`, `div_end` and `div_zero` are all 0. State is IDLE and the internal registers are 0.
- **FSM states:** IDLE, CALC, FIX.
- **IDLE, `div` = 1, `b` != 0:**
  - Latch |a| and |b| (magnitudes only when `is_signed`, otherwise raw).
  - Latch the quotient sign (a[W-1] XOR b[W-1]) and the remainder sign (a[W-1]), both masked by `is_signed`.
  - Clear the partial remainder and the bit counter.
  - Clear `div_zero`, set `busy`, go to CALC.
- **IDLE, `div` = 1, `b` == 0:**
  - Set `div_zero` and pulse `div_end` next cycle.
  - `high` and `low` keep their previous values. `busy` stays 0 and state stays IDLE.
- **CALC:** one restoring step per cycle, for exactly WIDTH cycles.
  - Shift {remainder, dividend} left by 1.
  - Trial-subtract the divisor in WIDTH+1-bit arithmetic.
  - If the result is non-negative, keep it and shift in quotient bit 1. Otherwise restore and shift in 0.
  - After step WIDTH, go to FIX.
- **FIX:**
  - Negate the quotient if its sign is set. Negate the remainder if its sign is set.
  - Write `low`/`high`, pulse `div_end`, clear `busy`, return to IDLE.
- **Signed semantics:**
  - Quotient truncates toward zero. The remainder has the sign of the dividend.
  - Overflow (MIN / −1) yields `low` = MIN and `high` = 0, with no flag. This falls out of modulo-2^WIDTH negation.
- **`div` while busy:** ignored, and not queued. Operands are not re-sampled during CALC/FIX.
- **`div` during the `div_end` cycle:** accepted, since state is IDLE. Back-to-back operations are legal.
- **`reset` mid-operation:** immediate return to IDLE with all outputs 0. No `div_end` is issued for the aborted operation.

## Timing
- Start is accepted at edge E0.
- **Normal case:** CALC occupies edges E0+1 … E0+WIDTH. FIX executes at edge E0+WIDTH+1.
  - `high`, `low` and `div_end` are valid in the cycle after that edge. Latency is WIDTH+1 edges (33 for WIDTH = 32).
  - `busy` is high for exactly WIDTH+1 cycles.
- **Divide by zero:** `div_zero` and `div_end` are high in the cycle after E0. Latency is 1.
- `div_end` is high for exactly one cycle per accepted operation.
- `high`, `low` and `div_zero` hold until the next completion or reset.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `div_pkg` holds:
  - the state enum (`DIV_IDLE`, `DIV_CALC`, `DIV_FIX`);
  - the state width constant;
  - the counter-width function (clog2(WIDTH+1)).
- Sub-module `div_step`: combinational single restoring iteration, parametrised by WIDTH.
  - Inputs: partial remainder, dividend MSB, divisor.
  - Outputs: next remainder, quotient bit.
  - The top level instantiates it once and iterates it across cycles.
- Magnitude and negation logic is inline in the top level.

## Test plan
- Unsigned 100 / 7, WIDTH = 32:
  - `low` = 14, `high` = 2.
  - `div_end` 33 edges after start; `busy` high for 33 cycles; `div_zero` = 0.
- Signed −7 / 2:
  - `low` = 0xFFFFFFFD (−3), `high` = 0xFFFFFFFF (−1).
- Signed 0x80000000 / 0xFFFFFFFF:
  - `low` = 0x80000000, `high` = 0.
- Divide by zero with prior result 14/2 held, then `a` = 5, `b` = 0:
  - `div_zero` = 1 and `div_end` one edge later.
  - `high` = 2, `low` = 14 unchanged. The next valid start clears `div_zero`.
- Start 1000 / 3 unsigned, pulse `div` again at cycle 5, assert `reset` at cycle 10:
  - The second `div` is ignored.
  - After reset, all outputs are 0 and no `div_end` appears.
  - A fresh 9 / 3 then gives `low` = 3, `high` = 0.
- WIDTH = 8, unsigned 0xFF / 0x10, with a second start issued in the `div_end` cycle:
  - `low` = 0x0F, `high` = 0x0F, latency 9.
  - The second operation is accepted and completes 9 edges later.
